// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time through IDLE -> ACCESS -> RESP, sized loads with sign extension.
// Compile-time option LSU_MISALIGN_EXC_EN: misaligned halfword/word accesses fault instead of being force-aligned.
module load_store_unit #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_we,
    output logic [1:0]        ram_mode,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              r_state;
    logic                r_we;
    logic                r_signed;
    logic                r_fault;
    logic                r_ram_we;
    logic [1:0]          r_ram_mode;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [31:0]         r_ram_wdata;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic [31:0]         r_resp_rdata;

    logic                w_fault;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_load_data;

`ifdef LSU_MISALIGN_EXC_EN
    assign w_fault = (req_size == 2'd3)
                   || ((req_size == 2'd0) && (req_addr[1:0] != 2'b00))
                   || ((req_size == 2'd1) && req_addr[0]);
    assign w_addr  = req_addr;
`else
    assign w_fault = (req_size == 2'd3);

    // Misaligned accesses are silently pulled down to their natural boundary.
    always_comb begin
        w_addr = req_addr;
        if (req_size == 2'd0)
            w_addr[1:0] = 2'b00;
        else if (req_size == 2'd1)
            w_addr[0] = 1'b0;
    end
`endif

    always_comb begin
        w_load_data = ram_rdata;
        if (r_signed && (r_ram_mode == 2'd1))
            w_load_data = {{16{ram_rdata[15]}}, ram_rdata[15:0]};
        else if (r_signed && (r_ram_mode == 2'd2))
            w_load_data = {{24{ram_rdata[7]}}, ram_rdata[7:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_signed     <= 1'b0;
            r_fault      <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_mode   <= 2'd0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_signed    <= req_signed;
                        r_fault     <= w_fault;
                        r_ram_mode  <= req_size;
                        r_ram_addr  <= w_addr;
                        r_ram_wdata <= req_wdata;
                        r_ram_we    <= req_we & ~w_fault;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The RAM answers combinationally, so the result is latched as ACCESS closes.
                    r_ram_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= r_fault;
                    r_resp_rdata <= (r_we || r_fault) ? 32'd0 : w_load_data;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign ram_we     = r_ram_we;
    assign ram_mode   = r_ram_mode;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-array RAM on the memory port, transaction-level golden memory
// and an expected-response queue checked every cycle resp_valid is high.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [11:0] req_addr = 12'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [1:0]  ram_mode;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;

    logic [7:0]  ram [0:4095];
    logic [7:0]  gm  [0:4095];
    logic [32:0] exp_q [$];

    load_store_unit #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_we(ram_we), .ram_mode(ram_mode), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Little-endian byte RAM: combinational, zero-extended read; write on the clock edge.
    always_comb begin
        logic [11:0] a;
        a = ram_addr;
        ram_rdata = 32'd0;
        case (ram_mode)
            2'd0: ram_rdata = {ram[a + 12'd3], ram[a + 12'd2], ram[a + 12'd1], ram[a]};
            2'd1: ram_rdata = {16'd0, ram[a + 12'd1], ram[a]};
            2'd2: ram_rdata = {24'd0, ram[a]};
            default: ram_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (ram_we) begin
            we_cnt++;
            case (ram_mode)
                2'd0: begin
                    ram[ram_addr]         <= ram_wdata[7:0];
                    ram[ram_addr + 12'd1] <= ram_wdata[15:8];
                    ram[ram_addr + 12'd2] <= ram_wdata[23:16];
                    ram[ram_addr + 12'd3] <= ram_wdata[31:24];
                end
                2'd1: begin
                    ram[ram_addr]         <= ram_wdata[7:0];
                    ram[ram_addr + 12'd1] <= ram_wdata[15:8];
                end
                2'd2: ram[ram_addr] <= ram_wdata[7:0];
                default: ;
            endcase
        end
    end

    // Response checker: every cycle a response is presented it must match the queue head.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected resp_valid", 32'd1, 32'd0);
            end else begin
                chk("resp_rdata vs model", resp_rdata, exp_q[0][31:0]);
                chk("resp_err vs model", {31'd0, resp_err}, {31'd0, exp_q[0][32]});
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One transaction; entered and left one time unit after a rising edge with the unit in IDLE.
    task automatic xact(input logic we, input logic [1:0] size, input logic sgn, input logic [11:0] addr,
                        input logic [31:0] wdata, input int hold, output logic [31:0] rdata, output logic err);
        logic        fault;
        logic [11:0] eaddr;
        logic [11:0] idx;
        logic [31:0] v;
        int          n;
        int          c0;
        fault = (size == 2'd3);
        eaddr = addr;
`ifdef LSU_MISALIGN_EXC_EN
        if ((size == 2'd0 && addr[1:0] != 2'b00) || (size == 2'd1 && addr[0])) fault = 1'b1;
`else
        if (size == 2'd0) eaddr = addr & 12'hFFC;
        if (size == 2'd1) eaddr = addr & 12'hFFE;
`endif
        n = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
        v = 32'd0;
        if (!fault && we) begin
            for (int i = 0; i < n; i++) begin
                idx = eaddr + 12'(i);
                gm[idx] = wdata[8*i +: 8];
            end
        end else if (!fault) begin
            for (int i = 0; i < n; i++) begin
                idx = eaddr + 12'(i);
                v = v | (32'(gm[idx]) << (8 * i));
            end
            if (sgn && size == 2'd1 && v[15]) v = v | 32'hFFFF0000;
            if (sgn && size == 2'd2 && v[7])  v = v | 32'hFFFFFF00;
        end
        exp_q.push_back({fault, v});

        chk("req_ready in IDLE", {31'd0, req_ready}, 32'd1);
        c0 = we_cnt;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("req_ready in ACCESS", {31'd0, req_ready}, 32'd0);
        chk("resp_valid in ACCESS", {31'd0, resp_valid}, 32'd0);
        chk("ram_we in ACCESS", {31'd0, ram_we}, {31'd0, we & ~fault});
        chk("ram_mode in ACCESS", {30'd0, ram_mode}, {30'd0, size});
        chk("ram_addr in ACCESS", {20'd0, ram_addr}, {20'd0, eaddr});
        if (we) chk("ram_wdata in ACCESS", ram_wdata, wdata);
        @(posedge clk); #1;
        chk("resp_valid two cycles after accept", {31'd0, resp_valid}, 32'd1);
        chk("ram_we after ACCESS", {31'd0, ram_we}, 32'd0);
        rdata = resp_rdata;
        err = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("held resp_rdata stable", resp_rdata, rdata);
            chk("req_ready low while held", {31'd0, req_ready}, 32'd0);
            chk("resp_valid held", {31'd0, resp_valid}, 32'd1);
        end
        chk("req_ready in retire cycle", {31'd0, req_ready}, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_valid after retire", {31'd0, resp_valid}, 32'd0);
        chk("req_ready after retire", {31'd0, req_ready}, 32'd1);
        chk("ram_we pulse count", 32'(we_cnt - c0), {31'd0, we & ~fault});
        $display("xact we=%0d size=%0d signed=%0d addr=0x%03h wdata=0x%08h -> rdata=0x%08h err=%0d",
                 we, size, sgn, addr, wdata, rdata, err);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"},  {31'd0, req_ready}, 32'd1);
        chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, " resp_err"},   {31'd0, resp_err}, 32'd0);
        chk({tag, " ram_we"},     {31'd0, ram_we}, 32'd0);
        chk({tag, " ram_mode"},   {30'd0, ram_mode}, 32'd0);
        chk({tag, " ram_addr"},   {20'd0, ram_addr}, 32'd0);
        chk({tag, " ram_wdata"},  ram_wdata, 32'd0);
        chk({tag, " resp_rdata"}, resp_rdata, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          diffs;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'd0;
            gm[i]  = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store then load
        xact(1'b1, 2'd0, 1'b0, 12'h010, 32'hDEADBEEF, 0, rd, er);
        chk("sw resp_rdata is zero", rd, 32'd0);
        xact(1'b0, 2'd0, 1'b0, 12'h010, 32'd0, 0, rd, er);
        chk("lw 0x010", rd, 32'hDEADBEEF);
        chk("lw 0x010 err", {31'd0, er}, 32'd0);

        // Byte sign extension
        xact(1'b1, 2'd2, 1'b0, 12'h023, 32'h000000F0, 0, rd, er);
        xact(1'b0, 2'd2, 1'b1, 12'h023, 32'd0, 0, rd, er);
        chk("lb 0x023", rd, 32'hFFFFFFF0);
        xact(1'b0, 2'd2, 1'b0, 12'h023, 32'd0, 0, rd, er);
        chk("lbu 0x023", rd, 32'h000000F0);

        // Halfword store into the upper half of a word
        xact(1'b1, 2'd0, 1'b0, 12'h030, 32'h11223344, 0, rd, er);
        xact(1'b1, 2'd1, 1'b0, 12'h032, 32'h00008001, 0, rd, er);
        xact(1'b0, 2'd0, 1'b0, 12'h030, 32'd0, 0, rd, er);
        chk("lw 0x030", rd, 32'h80013344);
        xact(1'b0, 2'd1, 1'b1, 12'h032, 32'd0, 0, rd, er);
        chk("lh 0x032", rd, 32'hFFFF8001);
        xact(1'b0, 2'd1, 1'b0, 12'h032, 32'd0, 0, rd, er);
        chk("lhu 0x032", rd, 32'h00008001);

        // Misaligned word access
        xact(1'b1, 2'd0, 1'b0, 12'h004, 32'hCAFEF00D, 0, rd, er);
`ifdef LSU_MISALIGN_EXC_EN
        xact(1'b0, 2'd0, 1'b0, 12'h005, 32'd0, 0, rd, er);
        chk("lw 0x005 err", {31'd0, er}, 32'd1);
        chk("lw 0x005 rdata", rd, 32'd0);
        xact(1'b1, 2'd0, 1'b0, 12'h005, 32'h55555555, 0, rd, er);
        chk("sw 0x005 err", {31'd0, er}, 32'd1);
        xact(1'b1, 2'd1, 1'b0, 12'h033, 32'h0000AAAA, 0, rd, er);
        chk("sh 0x033 err", {31'd0, er}, 32'd1);
        xact(1'b0, 2'd0, 1'b0, 12'h004, 32'd0, 0, rd, er);
        chk("memory after misaligned sw", rd, 32'hCAFEF00D);
`else
        xact(1'b0, 2'd0, 1'b0, 12'h005, 32'd0, 0, rd, er);
        chk("lw 0x005 aligned data", rd, 32'hCAFEF00D);
        chk("lw 0x005 err", {31'd0, er}, 32'd0);
        xact(1'b0, 2'd1, 1'b0, 12'h033, 32'd0, 0, rd, er);
        chk("lhu 0x033 aligned data", rd, 32'h00008001);
`endif

        // Illegal size, load and store
        xact(1'b0, 2'd3, 1'b0, 12'h010, 32'd0, 0, rd, er);
        chk("size3 load err", {31'd0, er}, 32'd1);
        chk("size3 load rdata", rd, 32'd0);
        xact(1'b1, 2'd3, 1'b0, 12'h010, 32'h01020304, 0, rd, er);
        chk("size3 store err", {31'd0, er}, 32'd1);
        xact(1'b0, 2'd0, 1'b0, 12'h010, 32'd0, 0, rd, er);
        chk("memory after size3 store", rd, 32'hDEADBEEF);

        // Top of the address range
        xact(1'b1, 2'd2, 1'b0, 12'hFFF, 32'h0000005A, 0, rd, er);
        xact(1'b0, 2'd2, 1'b1, 12'hFFF, 32'd0, 0, rd, er);
        chk("lb 0xFFF", rd, 32'h0000005A);

        // Backpressure: response held for 5 cycles
        xact(1'b0, 2'd0, 1'b0, 12'h030, 32'd0, 5, rd, er);
        chk("lw 0x030 under backpressure", rd, 32'h80013344);

        // Reset during the ACCESS cycle of a store
        req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 12'h040; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ram_we before reset pulse", {31'd0, ram_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("req_ready after reset", {31'd0, req_ready}, 32'd1);
        chk("resp_valid after reset", {31'd0, resp_valid}, 32'd0);
        $display("xact we=1 size=0 signed=0 addr=0x040 wdata=0x12345678 -> aborted by reset");
        xact(1'b0, 2'd0, 1'b0, 12'h040, 32'd0, 0, rd, er);
        chk("lw 0x040 after aborted store", rd, 32'd0);

        diffs = 0;
        for (int i = 0; i < 12'h050; i++)
            if (ram[i] !== gm[i]) diffs++;
        if (ram[12'hFFF] !== gm[12'hFFF]) diffs++;
        chk("RAM bytes differing from model", 32'(diffs), 32'd0);
        chk("responses left in queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the byte-address width of req_addr and ram_addr.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-low reset: clk (input, 1) is the single clock, rising edge; rst_n (input, 1) is the asynchronous active-low reset.
REQ-003 Request ports SHALL be:
- req_valid (input, 1): request present.
- req_ready (output, 1): unit can accept.
- req_we (input, 1): 1 = store, 0 = load.
- req_size (input, 2): 0 word, 1 halfword, 2 byte, 3 illegal.
- req_signed (input, 1): sign-extend loads.
- req_addr (input, ADDR_W): byte address.
- req_wdata (input, 32): store data, LSB-aligned.
REQ-004 Response ports SHALL be:
- resp_valid (output, 1): result held.
- resp_ready (input, 1): consumer takes result.
- resp_rdata (output, 32): extended load data, 0 for stores.
- resp_err (output, 1): access faulted.
REQ-005 RAM-side ports SHALL be:
- ram_we (output, 1): write strobe.
- ram_mode (output, 2): 0 word, 1 halfword, 2 byte.
- ram_addr (output, ADDR_W): byte address.
- ram_wdata (output, 32): LSB-aligned store data.
- ram_rdata (input, 32): combinational, zero-extended, LSB-aligned read data valid in the same cycle as ram_addr/ram_mode.

Function
REQ-006 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-007 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-008 When req_valid and req_ready are both 1 at a rising edge, the unit SHALL capture we, size, signed, addr and wdata, then move to ACCESS.
REQ-009 ACCESS SHALL last exactly one cycle and then move to RESP.
REQ-010 In ACCESS, ram_mode, ram_addr and ram_wdata SHALL be driven from the captured request.
REQ-011 In ACCESS, ram_we SHALL equal captured we and no fault; ram_we SHALL be 0 in every other cycle.
REQ-012 In ACCESS, ram_rdata SHALL be sampled at the closing edge.
REQ-013 Load data extension SHALL be:
- Halfword with signed: bit 15 replicated into [31:16].
- Byte with signed: bit 7 replicated into [31:8].
- Otherwise: ram_rdata passed unchanged.
REQ-014 Outside ACCESS, ram_mode, ram_addr and ram_wdata SHALL hold their last values, with ram_we = 0.
REQ-015 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be stable until resp_valid and resp_ready are both 1 at an edge; the unit then returns to IDLE.
REQ-016 Latency from the accept edge to resp_valid SHALL be 2 cycles; back-to-back throughput SHALL be one request per 3 cycles with resp_ready held 1.
REQ-017 A new request SHALL NOT be accepted in the cycle a response retires; req_ready rises the next cycle.
REQ-018 req_size = 3 SHALL set resp_err = 1, suppress ram_we, and give resp_rdata = 0, still via ACCESS and RESP.
REQ-019 A store response SHALL return resp_rdata = 0.
REQ-020 A faulted access SHALL leave memory contents unchanged.
REQ-021 Addresses at the top of the range SHALL pass through unmodified, with no wrap handling.

Reset
REQ-022 While rst_n = 0, asynchronously:
- The state SHALL be IDLE and req_ready = 1.
- resp_valid, resp_err and ram_we SHALL be 0.
- ram_mode, ram_addr, ram_wdata and resp_rdata SHALL be 0.
REQ-023 A reset asserted in ACCESS SHALL drop ram_we immediately; the in-flight store SHALL be treated as not committed, and no response is produced.
REQ-024 Reset release SHALL take effect at the first rising clk edge after rst_n rises.

Configuration
REQ-025 The macro LSU_MISALIGN_EXC_EN SHALL select alignment handling at compile time.
REQ-026 With LSU_MISALIGN_EXC_EN defined:
- A halfword access with addr[0] = 1 SHALL fault per REQ-018/REQ-020.
- A word access with addr[1:0] != 0 SHALL fault per REQ-018/REQ-020.
REQ-027 With LSU_MISALIGN_EXC_EN undefined, the unit SHALL clear the low address bits before driving ram_addr and SHALL raise no fault:
- Halfword access: addr[0] cleared.
- Word access: addr[1:0] cleared.

Verification
REQ-028 Word store then load: sw 0xDEADBEEF @0x010, then lw @0x010 -> ram_we high for one cycle with ram_mode = 0; load resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid 2 cycles after accept.
REQ-029 Byte sign extension: with 0x000000F0 stored at byte 0x023, lb signed @0x023 -> 0xFFFFFFF0; lbu @0x023 -> 0x000000F0.
REQ-030 Halfword store at the upper half: sh 0x8001 @0x032 over word 0x11223344, then lw @0x030 -> 0x80013344; lh signed @0x032 -> 0xFFFF8001.
REQ-031 Misaligned and illegal accesses:
- With the macro defined, lw @0x005 -> resp_err = 1, ram_we never high, memory unchanged.
- With the macro undefined, lw @0x005 -> ram_addr = 0x004, resp_err = 0.
- req_size = 3 -> resp_err = 1 in both builds.
REQ-032 Backpressure and reset: hold resp_ready = 0 for 5 cycles in RESP -> resp_rdata stable and req_ready = 0 throughout. Pulse rst_n low during the ACCESS of a store -> ram_we falls immediately and all outputs reach the REQ-022 reset values.
